// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer feeding cpu_fsm: loadable program RAM, PC, and a
// four-state sequencer that issues one instruction per done pulse and stops on HALT.
module instr_fetch #(
  parameter int                OP_SIZE  = 4,
  parameter int                ARG_SIZE = 3,
  parameter int                ARG_NUM  = 2,
  parameter int                ADDR_W   = 5,
  parameter logic [OP_SIZE-1:0] HALT_OP = 4'hF,
  localparam int               IW       = OP_SIZE + ARG_NUM*ARG_SIZE,
  localparam int               DEPTH    = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [IW-1:0]     prog_data,
  input  logic              done,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [IW-1:0]     instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [IW-1:0]     instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  logic [IW-1:0]     mem [DEPTH];
  logic              mem_we;
  logic [IW-1:0]     rd_word;

  // RAM has no reset so a program survives a sequencer reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_addr] <= prog_data;
  end

  // The instruction register acts as the synchronous read port: the word
  // addressed during FETCH is captured on the FETCH->ISSUE edge, so a write
  // taken together with start is already visible.
  assign rd_word = mem[pc_q];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_we = prog_we;
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_word[IW-1 -: OP_SIZE] == HALT_OP) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          instr_d = rd_word;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (done) begin
          pc_d    = branch ? branch_addr : pc_q + ADDR_W'(1);
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        mem_we = prog_we;
        if (start) begin
          halted_d = 1'b0;
          pc_d     = '0;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table of retire steps, hand-written corner
// sequences, and a randomized run against a transaction-level program model.
module tb_instr_fetch;
  localparam int IW = 10;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, prog_we = 1'b0, done = 1'b0, branch = 1'b0;
  logic [AW-1:0] prog_addr = '0, branch_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic [IW-1:0] instruction;
  logic          instr_valid, halted;
  logic [AW-1:0] pc;

  int ntests = 0;
  int nfail  = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .done(done),
    .branch(branch), .branch_addr(branch_addr), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          done;
    logic          branch;
    logic [AW-1:0] baddr;
    logic [IW-1:0] ei;
    logic [AW-1:0] ep;
    logic          ev;
    logic          eh;
  } vec_t;

  vec_t vt[8];

  // transaction-level model state
  logic [IW-1:0] m_mem [32];
  logic [IW-1:0] m_instr;
  int            m_pc;
  bit            m_active, m_halted;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [IW-1:0] ei, input logic [AW-1:0] ep,
                         input logic ev, input logic eh);
    chk({nm, ".instr"},  32'(instruction), 32'(ei));
    chk({nm, ".pc"},     32'(pc),          32'(ep));
    chk({nm, ".valid"},  32'(instr_valid), 32'(ev));
    chk({nm, ".halted"}, 32'(halted),      32'(eh));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [AW-1:0] a, input logic [IW-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic retire(input logic br, input logic [AW-1:0] ba);
    done = 1'b1; branch = br; branch_addr = ba;
    tick();
    done = 1'b0; branch = 1'b0;
  endtask

  function automatic logic [IW-1:0] rand_word();
    logic [3:0] op;
    logic [5:0] args;
    op   = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    args = 6'($urandom);
    return {op, args};
  endfunction

  // Issue outcome of the word at m_pc: either it is presented, or HALT stops the run.
  task automatic m_step();
    if (m_mem[m_pc][9:6] == 4'hF) begin
      m_halted = 1'b1;
      m_active = 1'b0;
    end else begin
      m_instr  = m_mem[m_pc];
      m_active = 1'b1;
    end
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 5'd0,  10'h08A, 5'd1,  1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b1, 5'd7,  10'h0C3, 5'd7,  1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 5'd3,  10'h0C3, 5'd7,  1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b0, 5'd0,  10'h2AA, 5'd8,  1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b1, 5'd31, 10'h155, 5'd31, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b0, 5'd0,  10'h041, 5'd0,  1'b1, 1'b0};
    vt[6] = '{1'b1, 1'b0, 5'd0,  10'h08A, 5'd1,  1'b1, 1'b0};
    vt[7] = '{1'b1, 1'b0, 5'd0,  10'h08A, 5'd2,  1'b0, 1'b1};

    #12;
    chk_out("reset", 10'h000, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();

    prog(5'd0, 10'h041); prog(5'd1, 10'h08A); prog(5'd2, 10'h3C0);
    prog(5'd3, 10'h1B7); prog(5'd7, 10'h0C3); prog(5'd8, 10'h2AA);
    prog(5'd31, 10'h155);

    start = 1'b1; tick(); start = 1'b0;
    chk_out("start_fetch", 10'h000, 5'd0, 1'b0, 1'b0);
    tick();
    chk_out("start_issue", 10'h041, 5'd0, 1'b1, 1'b0);

    foreach (vt[i]) begin
      done = vt[i].done; branch = vt[i].branch; branch_addr = vt[i].baddr;
      tick();
      done = 1'b0; branch = 1'b0;
      tick();
      chk_out($sformatf("vec%0d", i), vt[i].ei, vt[i].ep, vt[i].ev, vt[i].eh);
    end

    // restart from HALT after reprogramming word 0 while halted
    prog(5'd0, 10'h113);
    chk_out("halt_prog", 10'h08A, 5'd2, 1'b0, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    chk_out("restart_fetch", 10'h08A, 5'd0, 1'b0, 1'b0);
    tick();
    chk_out("restart_issue", 10'h113, 5'd0, 1'b1, 1'b0);

    // writes and start during ISSUE are ignored
    prog(5'd1, 10'h3FF);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk_out("issue_ignore", 10'h113, 5'd0, 1'b1, 1'b0);
    retire(1'b0, 5'd0);
    tick();
    chk_out("guard_mem1", 10'h08A, 5'd1, 1'b1, 1'b0);

    // done/branch held through FETCH: only the first retire counts
    done = 1'b1; branch = 1'b1; branch_addr = 5'd7;
    tick();
    branch_addr = 5'd8;
    tick();
    done = 1'b0; branch = 1'b0;
    chk_out("done_held", 10'h0C3, 5'd7, 1'b1, 1'b0);

    // asynchronous reset mid-cycle while in ISSUE
    #2 rst = 1'b0;
    #1 chk_out("async_rst", 10'h000, 5'd0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    tick();
    chk_out("post_rst_idle", 10'h000, 5'd0, 1'b0, 1'b0);

    // start and write to word 0 in the same IDLE cycle
    start = 1'b1; prog_we = 1'b1; prog_addr = 5'd0; prog_data = 10'h1C5;
    tick();
    start = 1'b0; prog_we = 1'b0;
    tick();
    chk_out("wr_start", 10'h1C5, 5'd0, 1'b1, 1'b0);
    retire(1'b1, 5'd3);
    tick();
    chk_out("ram_retained", 10'h1B7, 5'd3, 1'b1, 1'b0);

    // randomized run against the model
    rst = 1'b0; #3 rst = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      m_mem[a] = rand_word();
      prog(5'(a), m_mem[a]);
    end
    m_instr = '0; m_pc = 0; m_active = 1'b0; m_halted = 1'b0;
    for (int it = 0; it < 200; it++) begin
      if (!m_active) begin
        if ($urandom_range(0, 1) == 1) begin
          logic [AW-1:0] a;
          logic [IW-1:0] w;
          a = 5'($urandom); w = rand_word();
          prog(a, w);
          m_mem[a] = w;
        end
        start = 1'b1; tick(); start = 1'b0;
        m_pc = 0; m_halted = 1'b0;
        chk_out($sformatf("rnd%0d_fetch", it), m_instr, 5'(m_pc), 1'b0, 1'b0);
        tick();
        m_step();
        chk_out($sformatf("rnd%0d_start", it), m_instr, 5'(m_pc), m_active, m_halted);
      end else if ($urandom_range(0, 2) == 0) begin
        branch = 1'($urandom); branch_addr = 5'($urandom);
        start = 1'($urandom); prog_we = 1'($urandom);
        prog_addr = 5'($urandom); prog_data = rand_word();
        tick();
        branch = 1'b0; start = 1'b0; prog_we = 1'b0;
        chk_out($sformatf("rnd%0d_hold", it), m_instr, 5'(m_pc), 1'b1, 1'b0);
      end else begin
        logic          br;
        logic [AW-1:0] ba;
        br = 1'($urandom); ba = 5'($urandom);
        retire(br, ba);
        m_pc = br ? int'(ba) : (m_pc + 1) % 32;
        chk_out($sformatf("rnd%0d_fetch", it), m_instr, 5'(m_pc), 1'b0, 1'b0);
        tick();
        m_step();
        chk_out($sformatf("rnd%0d_next", it), m_instr, 5'(m_pc), m_active, m_halted);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
